gpin_ctrl: RTL

Sequencing and interrupt controller for the 32-bit general-purpose input bus assembled from the individual board input pins. Synchronises each line into the clock domain and debounces it on a programmable sample tick. Detects rising and falling edges on the debounced state and holds per-bit write-1-to-clear pending flags that drive a single interrupt line to the processor-side register block.

---
 rtl/gpin_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/gpin_ctrl.sv
// General-purpose input controller: synchronises and debounces the input bus,
// then latches enabled rising/falling edges as W1C pending flags behind one irq.
module gpin_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DIV_W      = 16,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpin,
  input  logic [DIV_W-1:0] tick_div,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] pending,
  output logic             irq,
  output logic             sample_stb
);

  localparam logic [3:0]       LAST    = 4'(STABLE_CNT - 1);
  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      sync1;
  logic [WIDTH-1:0]      sync2;
  logic [DIV_W-1:0]      cnt;
  logic [WIDTH-1:0][3:0] dcnt;
  logic [WIDTH-1:0][3:0] dcnt_next;
  logic [WIDTH-1:0]      state_next;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      fall;
  logic [WIDTH-1:0]      pending_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpin;
      sync2 <= sync1;
    end
  end

  // Compare with >= so lowering tick_div below cnt ticks at once instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sample_stb <= 1'b0;
    end else if (cnt >= tick_div) begin
      cnt        <= '0;
      sample_stb <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_ONE;
      sample_stb <= 1'b0;
    end
  end

  // A bit flips only after STABLE_CNT consecutive ticks disagreeing with its state.
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    if (sample_stb) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == state[i]) begin
          dcnt_next[i] = 4'd0;
        end else if (dcnt[i] == LAST) begin
          state_next[i] = ~state[i];
          dcnt_next[i]  = 4'd0;
        end else begin
          dcnt_next[i] = dcnt[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    rise         = state_next & ~state;
    fall         = ~state_next & state;
    pending_next = (pending & ~irq_clr) | (rise & rise_en) | (fall & fall_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= '0;
      dcnt    <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      state   <= state_next;
      dcnt    <= dcnt_next;
      pending <= pending_next;
      irq     <= |pending_next;
    end
  end

endmodule
